fetch_unit: RTL

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a valid/ready request to instruction memory.
- Delivers {pc_next_out, instruction_out} for IF/ID to capture each cycle.
- Absorbs hazard-unit stalls in a one-entry hold buffer and applies jump/branch redirects resolved in ID.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_hold_buf.sv | 28 ++
 rtl/fetch_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {START, FETCH, DROP, HOLD} fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_INC   = 32'd4;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc_next} skid buffer; clear has priority over load.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_next_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc_next
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid   <= 1'b0;
            instr   <= '0;
            pc_next <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            instr   <= instr_in;
            pc_next <= pc_next_in;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with imem, absorbs stalls and redirects.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_INC   = DEFAULT_PC_INC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_next_out,
    output logic [31:0] instruction_out,
    output logic        fetch_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_wait
`endif
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt, pc_inc;
    logic [31:0]  pending, pending_nxt;
    logic         redir;
    logic [31:0]  tgt;
    logic         buf_load, buf_clear, buf_valid;
    logic [31:0]  buf_instr, buf_pc_next;

    assign imem_addr = pc;

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .clear      (buf_clear),
        .instr_in   (imem_rdata),
        .pc_next_in (pc_inc),
        .valid      (buf_valid),
        .instr      (buf_instr),
        .pc_next    (buf_pc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= START;
            pc      <= RESET_PC;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        redir           = (jump | branch_taken) & ~stall;
        tgt             = jump ? jump_target : branch_target;
        pc_inc          = pc + PC_INC;
        state_nxt       = state;
        pc_nxt          = pc;
        pending_nxt     = pending;
        buf_load        = 1'b0;
        buf_clear       = 1'b0;
        imem_req        = 1'b0;
        instruction_out = NOP_INSTR;
        pc_next_out     = '0;
        fetch_valid     = 1'b0;

        case (state)
            START: state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (!imem_ready) begin
                    // The address must stay put until the in-flight response lands.
                    if (redir) begin
                        pending_nxt = tgt;
                        state_nxt   = DROP;
                    end
                end else if (redir) begin
                    pc_nxt = tgt;
                end else if (stall) begin
                    buf_load  = 1'b1;
                    pc_nxt    = pc_inc;
                    state_nxt = HOLD;
                end else begin
                    instruction_out = imem_rdata;
                    pc_next_out     = pc_inc;
                    fetch_valid     = 1'b1;
                    pc_nxt          = pc_inc;
                end
            end
            DROP: begin
                imem_req = 1'b1;
                if (redir) pending_nxt = tgt;
                if (imem_ready) begin
                    pc_nxt    = redir ? tgt : pending;
                    state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (!stall) begin
                    buf_clear = 1'b1;
                    state_nxt = FETCH;
                    if (redir) begin
                        pc_nxt = tgt;
                    end else if (buf_valid) begin
                        instruction_out = buf_instr;
                        pc_next_out     = buf_pc_next;
                        fetch_valid     = 1'b1;
                    end
                end
            end
            default: state_nxt = START;
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_wait    <= '0;
        end else begin
            if (fetch_valid)              perf_fetched <= perf_fetched + 32'd1;
            if (imem_req && !imem_ready)  perf_wait    <= perf_wait + 32'd1;
        end
    end
`endif

endmodule
